// File: rtl/risc_arb_pkg.sv
// Shared types and defaults for the RISC instruction/data memory arbiter.
//   arb_state_e : arbiter FSM state encoding
//   arb_owner_e : which requester owns the in-flight transaction
//   ARB_AW/DW   : default address/data widths
package risc_arb_pkg;

  localparam int unsigned ARB_AW = 32;
  localparam int unsigned ARB_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/risc_arb_starve_ctr.sv
// Saturating starvation counter for the fetch requester.
// Counts data grants issued while fetch is also waiting; once the count
// reaches STARVE_LIMIT, o_force_fetch makes fetch win the next collision.
// Ports:
//   i_clk, i_arst_n : clock, async active-low reset
//   i_idle          : arbiter FSM is in IDLE
//   i_if_req        : fetch request pending
//   i_if_grant      : fetch granted this cycle
//   i_d_grant       : data granted this cycle
//   o_force_fetch   : count has reached STARVE_LIMIT
module risc_arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_idle,
  input  logic i_if_req,
  input  logic i_if_grant,
  input  logic i_d_grant,
  output logic o_force_fetch
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_cnt <= '0;
    end else if (i_if_grant) begin
      r_cnt <= '0;
    end else if (i_d_grant && i_if_req) begin
      if (r_cnt != LIMIT) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else if (i_idle && !i_if_req) begin
      // Fetch went away on its own: it is no longer being starved.
      r_cnt <= '0;
    end
  end

  assign o_force_fetch = (r_cnt == LIMIT);

endmodule

// File: rtl/risc_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (if_*)
// and load/store (d_*). One outstanding transaction; winner is latched in
// IDLE, issued in ISSUE, awaited in WAIT, and returned in RESP.
// Ports:
//   i_clk, i_arst_n          : clock, async active-low reset
//   i_if_* / o_if_*          : fetch request, Mealy grant, response
//   i_d_* / o_d_*            : load/store request, Mealy grant, response
//   o_m_* / i_m_*            : memory request/grant/response handshake
//   o_busy                   : FSM not in IDLE
//   o_err                    : timeout response flag, valid with rvalid
// Build option: define RISC_ARB_TIMEOUT_EN to add a watchdog that ends a
// transaction with o_err=1 after TIMEOUT_CYCLES cycles in ISSUE/WAIT.
module risc_mem_arbiter
  import risc_arb_pkg::*;
#(
  parameter int unsigned AW             = ARB_AW,
  parameter int unsigned DW             = ARB_DW,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_arst_n,
  input  logic            i_if_req,
  input  logic [AW-1:0]   i_if_addr,
  output logic            o_if_gnt,
  output logic            o_if_rvalid,
  output logic [DW-1:0]   o_if_rdata,
  input  logic            i_d_req,
  input  logic            i_d_we,
  input  logic [AW-1:0]   i_d_addr,
  input  logic [DW-1:0]   i_d_wdata,
  input  logic [DW/8-1:0] i_d_be,
  output logic            o_d_gnt,
  output logic            o_d_rvalid,
  output logic [DW-1:0]   o_d_rdata,
  output logic            o_m_req,
  output logic            o_m_we,
  output logic [AW-1:0]   o_m_addr,
  output logic [DW-1:0]   o_m_wdata,
  output logic [DW/8-1:0] o_m_be,
  input  logic            i_m_gnt,
  input  logic            i_m_rvalid,
  input  logic [DW-1:0]   i_m_rdata,
  output logic            o_busy,
  output logic            o_err
);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  arb_owner_e       r_owner;
  logic [AW-1:0]    r_addr;
  logic             r_we;
  logic [DW-1:0]    r_wdata;
  logic [DW/8-1:0]  r_be;
  logic [DW-1:0]    r_if_rdata;
  logic [DW-1:0]    r_d_rdata;

  logic             w_grant_if;
  logic             w_grant_d;
  logic             w_capture;
  logic             w_timeout;
  logic             w_force_fetch;

  risc_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .i_clk         (i_clk),
    .i_arst_n      (i_arst_n),
    .i_idle        (r_state == IDLE),
    .i_if_req      (i_if_req),
    .i_if_grant    (w_grant_if),
    .i_d_grant     (w_grant_d),
    .o_force_fetch (w_force_fetch)
  );

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_d   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        // Grants are Mealy; qualify with reset so no grant escapes while
        // the arbiter is held in reset.
        if (i_arst_n) begin
          if (i_if_req && (!i_d_req || w_force_fetch)) begin
            w_grant_if = 1'b1;
          end else if (i_d_req) begin
            w_grant_d = 1'b1;
          end
        end
        if (w_grant_if || w_grant_d) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // m_rvalid without m_gnt is not ours and is ignored.
        if (i_m_gnt && i_m_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end else if (w_timeout) begin
          w_state_nxt = RESP;
        end else if (i_m_gnt) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (i_m_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end else if (w_timeout) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_owner    <= OWN_NONE;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_grant_if) begin
        // Fetches are always full-word reads.
        r_owner <= OWN_IF;
        r_addr  <= i_if_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
        r_be    <= '1;
      end else if (w_grant_d) begin
        r_owner <= OWN_D;
        r_addr  <= i_d_addr;
        r_we    <= i_d_we;
        r_wdata <= i_d_wdata;
        r_be    <= i_d_be;
      end

      if (w_capture) begin
        if (r_owner == OWN_IF) begin
          r_if_rdata <= i_m_rdata;
        end else if ((r_owner == OWN_D) && !r_we) begin
          // Store acknowledges carry no data; d_rdata keeps the last load.
          r_d_rdata <= i_m_rdata;
        end
      end else if (w_timeout) begin
        if (r_owner == OWN_IF) begin
          r_if_rdata <= '0;
        end else if (r_owner == OWN_D) begin
          r_d_rdata <= '0;
        end
      end
    end
  end

`ifdef RISC_ARB_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] r_wdog;
  logic          r_err;

  // Fires on the TIMEOUT_CYCLES-th cycle spent in ISSUE/WAIT.
  assign w_timeout = ((r_state == ISSUE) || (r_state == WAIT)) && (r_wdog == WDOG_LAST);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if ((r_state != ISSUE) && (w_state_nxt == ISSUE)) begin
        r_wdog <= '0;
      end else if (((r_state == ISSUE) || (r_state == WAIT)) && !w_timeout) begin
        r_wdog <= r_wdog + WW'(1);
      end
      // RESP is entered either with real data or by the watchdog.
      if ((r_state != RESP) && (w_state_nxt == RESP)) begin
        r_err <= !w_capture;
      end
    end
  end

  assign o_err = (r_state == RESP) && r_err;
`else
  // Watchdog not built; TIMEOUT_CYCLES is kept so both builds share one
  // parameter list.
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  assign o_if_gnt    = w_grant_if;
  assign o_d_gnt     = w_grant_d;
  assign o_if_rvalid = (r_state == RESP) && (r_owner == OWN_IF);
  assign o_d_rvalid  = (r_state == RESP) && (r_owner == OWN_D);
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rdata   = r_d_rdata;

  assign o_m_req   = (r_state == ISSUE);
  assign o_m_we    = r_we;
  assign o_m_addr  = r_addr;
  assign o_m_wdata = r_wdata;
  assign o_m_be    = r_be;

  assign o_busy = (r_state != IDLE);

endmodule
